// File: rtl/mips_prog_loader.sv
// mips_prog_loader: encodes symbolic MIPS instructions from a valid/ready
// stream and writes them to consecutive IMem words, holding the CPU in reset.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   start               pulse; opens a load session from IDLE or DONE
//   in_valid/in_ready   instruction handshake; in_last marks the final one
//   in_op..in_target    op select and raw register/immediate/target fields
//   mem_we/addr/wdata   IMem write port (one write per legal instruction)
//   cpu_reset_n, done   CPU released and load complete once DONE
//   err, count          sticky error flag and words written this session
module mips_prog_loader #(
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    localparam logic [4:0] OP_SLL  = 5'd0;
    localparam logic [4:0] OP_SRL  = 5'd1;
    localparam logic [4:0] OP_SLLV = 5'd2;
    localparam logic [4:0] OP_SRLV = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOR  = 5'd9;
    localparam logic [4:0] OP_SLT  = 5'd10;
    localparam logic [4:0] OP_LW   = 5'd11;
    localparam logic [4:0] OP_SW   = 5'd12;
    localparam logic [4:0] OP_BEQ  = 5'd13;
    localparam logic [4:0] OP_BNE  = 5'd14;
    localparam logic [4:0] OP_ADDI = 5'd15;
    localparam logic [4:0] OP_J    = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [ADDR_W:0]   cnt_eff;
    logic [ADDR_W:0]   count_inc;
    logic              accept;

    function automatic logic [31:0] r_word(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

    // Encoder: fields not used by the format are forced to zero.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_op)
            OP_SLL:  enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'b000000);
            OP_SRL:  enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'b000010);
            OP_SLLV: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b000100);
            OP_SRLV: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b000110);
            OP_ADD:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100000);
            OP_SUB:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100010);
            OP_AND:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100100);
            OP_OR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100101);
            OP_XOR:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100110);
            OP_NOR:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100111);
            OP_SLT:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b101010);
            OP_LW:   enc_word = i_word(6'b100011, in_rs, in_rt, in_imm);
            OP_SW:   enc_word = i_word(6'b101011, in_rs, in_rt, in_imm);
            OP_BEQ:  enc_word = i_word(6'b000100, in_rs, in_rt, in_imm);
            OP_BNE:  enc_word = i_word(6'b000101, in_rs, in_rt, in_imm);
            OP_ADDI: enc_word = i_word(6'b001000, in_rs, in_rt, in_imm);
            OP_J:    enc_word = {6'b000010, in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    // A registered write is still pending while we_q is high, so it is
    // counted here to keep back-to-back accepts from overrunning IMem.
    assign cnt_eff   = count_q + (ADDR_W + 1)'(we_q);
    assign count_inc = count_q + 1'b1;
    assign in_ready  = (state_q == S_LOAD) && (cnt_eff < DEPTH);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;

        // Retire the pending write; the address holds at the last slot.
        if (we_q) begin
            count_d = count_inc;
            if (count_inc < DEPTH) begin
                addr_d = addr_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                    addr_d  = BASE;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (enc_legal) begin
                        we_d    = 1'b1;
                        wdata_d = enc_word;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_WAIT;
                    end
                end else if (in_valid) begin
                    // Offered with no room left: overflow ends the session.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                state_d = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign done        = (state_q == S_DONE);
    // Drops as soon as a restarting start is seen in DONE.
    assign cpu_reset_n = done && !start;
    assign err         = err_q;
    assign count       = count_q;

endmodule
